// File: rtl/id_pair_packer.sv
// rtl/id_pair_packer.sv - packs PAIR_WIDTH ID pairs LSB-first into BUS_WIDTH AXI-Stream beats.
// Optional ID_PAIR_PACKER_CNT_EN adds the o_PairCount accepted-pair counter.
module id_pair_packer #(
  parameter int BUS_WIDTH      = 512,
  parameter int VEC_ID_WIDTH   = 8,
  parameter int PAIR_WIDTH     = 2 * VEC_ID_WIDTH,
  parameter int PAIRS_PER_BEAT = BUS_WIDTH / PAIR_WIDTH
) (
  input  logic                   ap_clk,
  input  logic                   ap_rstn,
  input  logic [PAIR_WIDTH-1:0]  S_AXIS_ID_PAIR_tdata,
  input  logic                   S_AXIS_ID_PAIR_tvalid,
  input  logic                   S_AXIS_ID_PAIR_tlast,
  output logic                   S_AXIS_ID_PAIR_tready,
  output logic [BUS_WIDTH-1:0]   M_AXIS_PACKED_tdata,
  output logic [BUS_WIDTH/8-1:0] M_AXIS_PACKED_tkeep,
  output logic                   M_AXIS_PACKED_tvalid,
  output logic                   M_AXIS_PACKED_tlast,
  input  logic                   M_AXIS_PACKED_tready
`ifdef ID_PAIR_PACKER_CNT_EN
  ,
  output logic [31:0]            o_PairCount
`endif
);

  localparam int KEEP_W         = BUS_WIDTH / 8;
  localparam int BYTES_PER_PAIR = PAIR_WIDTH / 8;
  localparam int SLOT_W         = (PAIRS_PER_BEAT > 1) ? $clog2(PAIRS_PER_BEAT) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PAIRS_PER_BEAT - 1);

  if (((PAIR_WIDTH % 8) != 0) || ((BUS_WIDTH % PAIR_WIDTH) != 0)) begin : g_bad_params
    $error("id_pair_packer: PAIR_WIDTH must be a multiple of 8 and divide BUS_WIDTH");
  end

  logic [BUS_WIDTH-1:0] acc_q, acc_d, acc_fill;
  logic [KEEP_W-1:0]    keep_fill;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [BUS_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_W-1:0]    m_keep_q, m_keep_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 s_fire, m_fire, close_beat;

  // The input may only advance when the output register is free or being drained this cycle.
  assign S_AXIS_ID_PAIR_tready = !m_valid_q || M_AXIS_PACKED_tready;
  assign s_fire     = S_AXIS_ID_PAIR_tvalid && S_AXIS_ID_PAIR_tready;
  assign m_fire     = m_valid_q && M_AXIS_PACKED_tready;
  assign close_beat = s_fire && (S_AXIS_ID_PAIR_tlast || (slot_q == LAST_SLOT));

  always_comb begin
    acc_fill  = acc_q;
    keep_fill = '0;
    for (int k = 0; k < PAIRS_PER_BEAT; k++) begin
      if (SLOT_W'(k) == slot_q) begin
        acc_fill[k*PAIR_WIDTH +: PAIR_WIDTH] = S_AXIS_ID_PAIR_tdata;
      end
      if (SLOT_W'(k) <= slot_q) begin
        keep_fill[k*BYTES_PER_PAIR +: BYTES_PER_PAIR] = '1;
      end
    end
  end

  always_comb begin
    acc_d     = acc_q;
    slot_d    = slot_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (s_fire) begin
      acc_d  = acc_fill;
      slot_d = slot_q + SLOT_W'(1);
    end
    if (m_fire) begin
      m_valid_d = 1'b0;
    end
    // A close overrides the drain so back-to-back beats keep tvalid high.
    if (close_beat) begin
      acc_d     = '0;
      slot_d    = '0;
      m_data_d  = acc_fill;
      m_keep_d  = keep_fill;
      m_last_d  = S_AXIS_ID_PAIR_tlast;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      acc_q     <= '0;
      slot_q    <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      slot_q    <= slot_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign M_AXIS_PACKED_tdata  = m_data_q;
  assign M_AXIS_PACKED_tkeep  = m_keep_q;
  assign M_AXIS_PACKED_tvalid = m_valid_q;
  assign M_AXIS_PACKED_tlast  = m_last_q;

`ifdef ID_PAIR_PACKER_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // A pair accepted on the same edge as the job-ending handshake is the first of the next job.
  always_comb begin
    cnt_d = cnt_q;
    if (m_fire && m_last_q) begin
      cnt_d = s_fire ? 32'd1 : 32'd0;
    end else if (s_fire) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_PairCount = cnt_q;
`endif

endmodule

// File: tb/tb_id_pair_packer.sv
// tb/tb_id_pair_packer.sv - self-checking bench for id_pair_packer; pair-list reference model.
module tb_id_pair_packer;

  localparam int BW  = 512;
  localparam int PW  = 16;
  localparam int PPB = BW / PW;
  localparam int KW  = BW / 8;

  logic          ap_clk;
  logic          ap_rstn;
  logic [PW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [BW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
`ifdef ID_PAIR_PACKER_CNT_EN
  logic [31:0]   pair_count;
`endif

  typedef struct {
    logic [BW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t         got_q[$];
  beat_t         exp_q[$];
  logic [PW-1:0] pend_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            accept_cycle = 0;

  id_pair_packer dut (
    .ap_clk                (ap_clk),
    .ap_rstn               (ap_rstn),
    .S_AXIS_ID_PAIR_tdata  (s_tdata),
    .S_AXIS_ID_PAIR_tvalid (s_tvalid),
    .S_AXIS_ID_PAIR_tlast  (s_tlast),
    .S_AXIS_ID_PAIR_tready (s_tready),
    .M_AXIS_PACKED_tdata   (m_tdata),
    .M_AXIS_PACKED_tkeep   (m_tkeep),
    .M_AXIS_PACKED_tvalid  (m_tvalid),
    .M_AXIS_PACKED_tlast   (m_tlast),
    .M_AXIS_PACKED_tready  (m_tready)
`ifdef ID_PAIR_PACKER_CNT_EN
    ,
    .o_PairCount           (pair_count)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Record each output beat on the cycle its handshake is pending.
  always @(negedge ap_clk) begin
    if (ap_rstn && m_tvalid && m_tready) begin
      got_q.push_back('{m_tdata, m_tkeep, m_tlast, cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: pairs collect in a list; a beat is emitted when the list is full or a tlast pair arrives.
  function automatic void model_pair(input logic [PW-1:0] d, input logic l);
    beat_t b;
    pend_q.push_back(d);
    if (l || pend_q.size() == PPB) begin
      b.data = '0;
      b.last = l;
      b.cyc  = 0;
      foreach (pend_q[k]) b.data = b.data | (BW'(pend_q[k]) << (PW * k));
      b.keep = (pend_q.size() == PPB) ? {KW{1'b1}} : ((KW'(1) << (2 * pend_q.size())) - KW'(1));
      exp_q.push_back(b);
      pend_q.delete();
    end
  endfunction

  task automatic push_pair(input logic [PW-1:0] d, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge ap_clk);
    while (!s_tready && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: s_tready=%0b required 1 within 300 cycles", s_tready);
    end
    @(posedge ap_clk);
    #1;
    accept_cycle = cyc;
    model_pair(d, l);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic test_reset();
    ap_rstn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    #12;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: tvalid=%0b tlast=%0b required 0 0", m_tvalid, m_tlast);
    end
    checks++;
    if (m_tdata !== '0 || m_tkeep !== '0) begin
      errors++;
      $display("FAIL reset_data: tdata=%0h tkeep=%0h required 0 0", m_tdata, m_tkeep);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: s_tready=%0b required 1", s_tready);
    end
    @(posedge ap_clk);
    #1;
    ap_rstn = 1'b1;
    settle(1);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: s_tready=%0b m_tvalid=%0b required 1 0", s_tready, m_tvalid);
    end
    clear_queues();
  endtask

  task automatic test_full_beat();
    logic [BW-1:0] e = '0;
    clear_queues();
    m_tready = 1'b1;
    for (int i = 0; i < PPB; i++) push_pair(PW'(i), i == PPB - 1);
    for (int k = 0; k < PPB; k++) e[k*PW +: PW] = PW'(k);
    settle(3);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL full_count: beats=%0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== e) begin
        errors++;
        $display("FAIL full_data: got %0h required %0h", got_q[0].data, e);
      end
      checks++;
      if (got_q[0].keep !== {KW{1'b1}} || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL full_keep_last: keep=%0h last=%0b required all-ones 1", got_q[0].keep, got_q[0].last);
      end
      checks++;
      if (got_q[0].cyc != accept_cycle) begin
        errors++;
        $display("FAIL full_latency: beat cycle=%0d required %0d", got_q[0].cyc, accept_cycle);
      end
    end
  endtask

  task automatic test_partial();
    logic [BW-1:0] e = '0;
    clear_queues();
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) push_pair(16'hA1B2 + PW'(i), i == 4);
    for (int k = 0; k < 5; k++) e[k*PW +: PW] = 16'hA1B2 + PW'(k);
    settle(3);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL partial_count: beats=%0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== e || got_q[0].data[BW-1:80] !== '0) begin
        errors++;
        $display("FAIL partial_data: got %0h required %0h", got_q[0].data, e);
      end
      checks++;
      if (got_q[0].keep !== 64'h3FF || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL partial_keep_last: keep=%0h last=%0b required 3ff 1", got_q[0].keep, got_q[0].last);
      end
    end
  endtask

  task automatic test_single();
    clear_queues();
    m_tready = 1'b1;
    push_pair(16'h1234, 1'b1);
    settle(3);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: beats=%0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== BW'(16'h1234) || got_q[0].keep !== 64'h3 || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL single_beat: data=%0h keep=%0h last=%0b required 1234 3 1", got_q[0].data, got_q[0].keep, got_q[0].last);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * PPB; i++) push_pair(16'h0100 + PW'(i), i == 2 * PPB - 1);
      end
      begin
        int n = 0;
        beat_t held;
        @(negedge ap_clk);
        while (!m_tvalid && n < 100) begin
          @(negedge ap_clk);
          n++;
        end
        checks++;
        if (!m_tvalid) begin
          errors++;
          $display("FAIL stall_wait: m_tvalid=%0b required 1 within 100 cycles", m_tvalid);
        end
        held = '{m_tdata, m_tkeep, m_tlast, 0};
        for (int c = 0; c < 10; c++) begin
          @(negedge ap_clk);
          checks++;
          if (s_tready !== 1'b0 || m_tdata !== held.data || m_tkeep !== held.keep || m_tlast !== held.last) begin
            errors++;
            $display("FAIL stall_hold: s_tready=%0b data=%0h required 0 %0h", s_tready, m_tdata, held.data);
          end
        end
        @(posedge ap_clk);
        #1;
        m_tready = 1'b1;
      end
    join
    settle(3);
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: beats=%0d required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i].data !== exp_q[i].data || got_q[i].keep !== exp_q[i].keep || got_q[i].last !== exp_q[i].last) begin
          errors++;
          $display("FAIL b2b_beat%0d: data=%0h required %0h", i, got_q[i].data, exp_q[i].data);
        end
      end
      checks++;
      if (got_q[1].cyc - got_q[0].cyc != PPB) begin
        errors++;
        $display("FAIL b2b_gap: beat spacing=%0d required %0d", got_q[1].cyc - got_q[0].cyc, PPB);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] e = '0;
    clear_queues();
    m_tready = 1'b1;
    for (int i = 0; i < 7; i++) push_pair(16'h7700 + PW'(i), 1'b0);
    #2;
    ap_rstn = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: s_tready=%0b m_tvalid=%0b required 1 0", s_tready, m_tvalid);
    end
    @(posedge ap_clk);
    #1;
    ap_rstn = 1'b1;
    clear_queues();
    for (int i = 0; i < 3; i++) push_pair(16'hC300 + PW'(i), i == 2);
    for (int k = 0; k < 3; k++) e[k*PW +: PW] = 16'hC300 + PW'(k);
    settle(3);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: beats=%0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== e || got_q[0].keep !== 64'h3F || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL midreset_beat: data=%0h keep=%0h required %0h 3f", got_q[0].data, got_q[0].keep, e);
      end
    end
  endtask

  task automatic test_random();
    bit done = 0;
    clear_queues();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
          repeat (idle) begin
            @(posedge ap_clk);
            #1;
          end
          push_pair(PW'($urandom), ($urandom_range(0, 9) == 0) || (i == 299));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge ap_clk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    settle(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: beats=%0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].keep !== exp_q[i].keep || got_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rand_beat%0d: data=%0h keep=%0h last=%0b required %0h %0h %0b", i, got_q[i].data, got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

`ifdef ID_PAIR_PACKER_CNT_EN
  task automatic test_pair_count();
    ap_rstn = 1'b0;
    #3;
    ap_rstn = 1'b1;
    clear_queues();
    m_tready = 1'b1;
    settle(1);
    for (int i = 0; i < 40; i++) push_pair(PW'(i), i == 39);
    checks++;
    if (pair_count !== 32'd40) begin
      errors++;
      $display("FAIL count_peak: o_PairCount=%0d required 40", pair_count);
    end
    settle(1);
    checks++;
    if (pair_count !== 32'd0) begin
      errors++;
      $display("FAIL count_clear: o_PairCount=%0d required 0", pair_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_beat();
    test_partial();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef ID_PAIR_PACKER_CNT_EN
    test_pair_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
